// File: rtl/icache_line_server_pkg.sv
// Shared types for the icache refill path: bus widths, line size and line-server FSM states.
package icache_line_server_pkg;

  typedef logic [31:0]  bus32_t;
  typedef logic [255:0] bus256_t;

  localparam int unsigned ICACHE_LINE_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP,
    COOL
  } line_srv_state_t;

endpackage

// File: rtl/icache_line_server_if.sv
// Icache refill handshake: level request plus address in, one-cycle line return out.
interface icache_line_server_if;
  import icache_line_server_pkg::*;

  logic    rd_req;
  bus32_t  rd_addr;
  logic    ret_valid;
  bus256_t ret_data;
  logic    busy;

  modport master (
    output rd_req, rd_addr,
    input  ret_valid, ret_data, busy
  );

  modport slave (
    input  rd_req, rd_addr,
    output ret_valid, ret_data, busy
  );

endinterface

// File: rtl/icache_line_server.sv
// Memory-side icache refill responder: fetches one line word-by-word from a pipelined
// instruction memory port and returns it as a single 256-bit beat.
module icache_line_server
  import icache_line_server_pkg::*;
#(
  parameter int unsigned LINE_WORDS  = ICACHE_LINE_WORDS,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  icache_line_server_if.slave   bus,
  output logic                  mem_en,
  output bus32_t                mem_addr,
  input  bus32_t                mem_rdata
);

  localparam int unsigned CW = $clog2(LINE_WORDS) + 1;
  localparam int unsigned SW = $clog2(LINE_WORDS);

  line_srv_state_t            state, state_nxt;
  bus32_t                     base;
  logic [CW-1:0]              issue_cnt;
  logic [CW-1:0]              recv_cnt;
  logic [MEM_LATENCY-1:0]     vpipe;
  bus32_t [LINE_WORDS-1:0]    line_q;
  logic                       rd_valid;
  logic                       accept;
  logic                       last_recv;

  // Issue strobes delayed by the memory latency mark the cycles mem_rdata is valid.
  assign rd_valid  = vpipe[MEM_LATENCY-1];
  assign accept    = (state == IDLE) && bus.rd_req;
  assign last_recv = rd_valid && (recv_cnt == CW'(LINE_WORDS - 1));
  assign bus.ret_data = line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.ret_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.rd_req) state_nxt = FETCH;
      end
      FETCH: if (last_recv) state_nxt = RESP;
      RESP: begin
        bus.ret_valid = 1'b1;
        state_nxt     = COOL;
      end
      COOL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      vpipe     <= '0;
      line_q    <= '0;
    end else begin
      mem_en <= 1'b0;
      vpipe  <= MEM_LATENCY'({vpipe, mem_en});

      if (accept) begin
        base      <= bus.rd_addr & ~32'h1F;
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end

      // Word offset never exceeds the line, so the add cannot carry past bit 4.
      if (state == FETCH && issue_cnt != CW'(LINE_WORDS)) begin
        mem_en    <= 1'b1;
        mem_addr  <= base + (32'(issue_cnt) << 2);
        issue_cnt <= issue_cnt + 1'b1;
      end

      if (state == FETCH && rd_valid) begin
        line_q[recv_cnt[SW-1:0]] <= mem_rdata;
        recv_cnt                 <= recv_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_line_server.sv
// Directed bench for icache_line_server: latency-1 and latency-3 instances, memory words equal their address.
module tb_icache_line_server;
  import icache_line_server_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_line_server_if if1();
  icache_line_server_if if3();

  logic   mem_en1, mem_en3;
  bus32_t mem_addr1, mem_addr3;
  bus32_t rdata1;
  bus32_t rp3 [3];

  icache_line_server #(.LINE_WORDS(8), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1),
    .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_rdata(rdata1)
  );

  icache_line_server #(.LINE_WORDS(8), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3),
    .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_rdata(rp3[2])
  );

  // Pipelined memory models: returned word equals the address presented.
  always @(posedge clk) rdata1 <= mem_addr1;
  always @(posedge clk) begin
    rp3[0] <= mem_addr3;
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit sel, input logic req, input bus32_t addr);
    if (sel) begin
      if3.rd_req  = req;
      if3.rd_addr = addr;
    end else begin
      if1.rd_req  = req;
      if1.rd_addr = addr;
    end
  endtask

  task automatic peek(input bit sel, output logic en, output bus32_t addr,
                      output logic rv, output bus256_t rd, output logic bsy);
    en   = sel ? mem_en3       : mem_en1;
    addr = sel ? mem_addr3     : mem_addr1;
    rv   = sel ? if3.ret_valid : if1.ret_valid;
    rd   = sel ? if3.ret_data  : if1.ret_data;
    bsy  = sel ? if3.busy      : if1.busy;
  endtask

  task automatic check_idle(input bit sel, input string tag);
    logic en, rv, bsy;
    bus32_t a;
    bus256_t rd;
    peek(sel, en, a, rv, rd, bsy);
    expect_eq({tag, " mem_en"}, en, 1'b0);
    expect_eq({tag, " mem_addr"}, a, 32'h0);
    expect_eq({tag, " ret_valid"}, rv, 1'b0);
    expect_eq({tag, " ret_data"}, rd, '0);
    expect_eq({tag, " busy"}, bsy, 1'b0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge two cycles after ret_valid.
  task automatic fetch_line(input bit sel, input bus32_t addr, input int drop_k,
                            input bit keep, input bus32_t next_addr);
    int      lat   = sel ? 3 : 1;
    int      ret_k = 8 + lat + 1;
    bus32_t  base  = addr & 32'hFFFF_FFE0;
    bus256_t exp_line;
    logic    req   = 1'b1;
    logic    en, rv, bsy;
    bus32_t  a;
    bus256_t rd;
    for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = base + 32'(4*i);
    set_req(sel, 1'b1, addr);
    @(posedge clk);
    for (int k = 0; k <= ret_k + 2; k++) begin
      @(negedge clk);
      peek(sel, en, a, rv, rd, bsy);
      expect_eq($sformatf("L%0d %h mem_en@%0d", lat, addr, k), en, (k >= 1 && k <= 8));
      if (k >= 1 && k <= 8)
        expect_eq($sformatf("L%0d %h mem_addr@%0d", lat, addr, k), a, base + 32'(4*(k-1)));
      expect_eq($sformatf("L%0d %h ret_valid@%0d", lat, addr, k), rv, (k == ret_k));
      expect_eq($sformatf("L%0d %h busy@%0d", lat, addr, k), bsy, (k <= ret_k + 1));
      if (k == ret_k)
        expect_eq($sformatf("L%0d %h ret_data", lat, addr), rd, exp_line);
      if (k == drop_k) req = 1'b0;
      if (k == ret_k) begin
        req = keep;
        set_req(sel, req, keep ? next_addr : addr);
      end else begin
        set_req(sel, req, (k >= 2) ? 32'hDEAD_BEE4 : addr);
      end
    end
  endtask

  initial begin
    logic    en, rv, bsy;
    bus32_t  a;
    bus256_t rd;
    set_req(1'b0, 1'b0, 32'h0);
    set_req(1'b1, 1'b0, 32'h0);

    @(negedge clk);
    check_idle(1'b0, "reset L1");
    check_idle(1'b1, "reset L3");
    rst = 1'b0;

    fetch_line(1'b0, 32'h0000_0040, -1, 1'b0, 32'h0);
    fetch_line(1'b0, 32'h0000_0054, -1, 1'b0, 32'h0);
    fetch_line(1'b0, 32'h0000_0060, -1, 1'b1, 32'h0000_0080);
    fetch_line(1'b0, 32'h0000_0080, -1, 1'b0, 32'h0);
    fetch_line(1'b0, 32'hFFFF_FFE8, -1, 1'b0, 32'h0);

    // Asynchronous reset between edges in the middle of a fetch.
    set_req(1'b0, 1'b1, 32'h0000_0040);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_idle(1'b0, "async rst");
    set_req(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      peek(1'b0, en, a, rv, rd, bsy);
      expect_eq($sformatf("post-rst ret_valid@%0d", k), rv, 1'b0);
      expect_eq($sformatf("post-rst busy@%0d", k), bsy, 1'b0);
    end
    fetch_line(1'b0, 32'h0000_0100, -1, 1'b0, 32'h0);

    fetch_line(1'b1, 32'h0000_0200, 1, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
